// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Brief    : Opcode/funct constants, FSM state codes and datapath select codes
//            shared by the multi-cycle control unit.
// Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    localparam logic [2:0] c_s_fetch  = 3'd0;
    localparam logic [2:0] c_s_decode = 3'd1;
    localparam logic [2:0] c_s_exec   = 3'd2;
    localparam logic [2:0] c_s_mem    = 3'd3;
    localparam logic [2:0] c_s_wb     = 3'd4;

    // Bit positions of the one-hot instruction class vector
    localparam int c_cls_addu = 0;
    localparam int c_cls_subu = 1;
    localparam int c_cls_ori  = 2;
    localparam int c_cls_lui  = 3;
    localparam int c_cls_lw   = 4;
    localparam int c_cls_sw   = 5;
    localparam int c_cls_beq  = 6;
    localparam int c_cls_jal  = 7;
    localparam int c_cls_jr   = 8;
    localparam int c_cls_nop  = 9;
    localparam int c_cls_w    = 10;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_or    = 2'b10;
    localparam logic [1:0] c_alu_passb = 2'b11;

    localparam logic [1:0] c_ext_zero  = 2'b00;
    localparam logic [1:0] c_ext_sign  = 2'b01;
    localparam logic [1:0] c_ext_lui   = 2'b10;

    localparam logic [1:0] c_rd_rt     = 2'b00;
    localparam logic [1:0] c_rd_rd     = 2'b01;
    localparam logic [1:0] c_rd_ra     = 2'b10;

    localparam logic [1:0] c_pc_seq    = 2'b00;
    localparam logic [1:0] c_pc_br     = 2'b01;
    localparam logic [1:0] c_pc_jal    = 2'b10;
    localparam logic [1:0] c_pc_jr     = 2'b11;

    localparam logic [3:0] c_m2r_alu   = 4'd0;
    localparam logic [3:0] c_m2r_dm    = 4'd1;
    localparam logic [3:0] c_m2r_ext   = 4'd2;
    localparam logic [3:0] c_m2r_pc4   = 4'd3;

    typedef logic [c_cls_w-1:0] cls_t;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluctrl;
        logic [1:0] extop;
    } alusel_t;

    // ALU operand/operation selects for the classes that use the ALU after DECODE
    function automatic alusel_t alu_sel(input cls_t cls);
        alusel_t r;
        r = '{alusrc: 1'b0, aluctrl: c_alu_add, extop: c_ext_zero};
        if (cls[c_cls_subu]) begin
            r.aluctrl = c_alu_sub;
        end else if (cls[c_cls_ori]) begin
            r.alusrc  = 1'b1;
            r.aluctrl = c_alu_or;
        end else if (cls[c_cls_lui]) begin
            r.alusrc  = 1'b1;
            r.aluctrl = c_alu_passb;
            r.extop   = c_ext_lui;
        end else if (cls[c_cls_lw] || cls[c_cls_sw]) begin
            r.alusrc  = 1'b1;
            r.extop   = c_ext_sign;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Brief    : Combinational instruction decoder: one-hot class plus illegal.
// Revision : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] i_instr,
    output cls_t        o_cls,
    output logic        o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    // Only the all-zero word is a nop; any other funct-0 R-type is undecoded
    always_comb begin
        o_cls     = '0;
        o_illegal = 1'b0;
        if (i_instr == 32'd0) begin
            o_cls[c_cls_nop] = 1'b1;
        end else begin
            case (w_opcode)
                c_op_rtype: begin
                    case (w_funct)
                        c_fn_addu: o_cls[c_cls_addu] = 1'b1;
                        c_fn_subu: o_cls[c_cls_subu] = 1'b1;
                        c_fn_jr:   o_cls[c_cls_jr]   = 1'b1;
                        default:   o_illegal         = 1'b1;
                    endcase
                end
                c_op_ori: o_cls[c_cls_ori] = 1'b1;
                c_op_lui: o_cls[c_cls_lui] = 1'b1;
                c_op_lw:  o_cls[c_cls_lw]  = 1'b1;
                c_op_sw:  o_cls[c_cls_sw]  = 1'b1;
                c_op_beq: o_cls[c_cls_beq] = 1'b1;
                c_op_jal: o_cls[c_cls_jal] = 1'b1;
                default:  o_illegal        = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle control unit (FETCH/DECODE/EXEC/MEM/WB) with a
//            mem_req/mem_ack handshake and bounded memory wait.
//            Optional MC_CTRL_PERF_EN adds cycle/retire counters.
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    output logic        irwrite,
    output logic        cpc,
    output logic        isbeq,
    output logic [1:0]  cpcop,
    output logic        regwrite,
    output logic        memwrite,
    output logic        mem_req,
    output logic        alusrc,
    output logic [1:0]  aluctrl,
    output logic [1:0]  extop,
    output logic [1:0]  regdst,
    output logic [3:0]  memtoreg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    localparam logic [3:0] c_wait_max  = 4'(MAX_WAIT);
    localparam logic [3:0] c_wait_last = 4'(MAX_WAIT - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [3:0] r_wait;
    logic       r_illegal;
    logic       r_timeout;
    cls_t       w_cls;
    logic       w_illegal;
    alusel_t    w_alu;
    logic       w_expire;
    logic       w_dec_done;

    mc_decode u_decode (
        .i_instr   (instr),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    assign w_alu      = alu_sel(w_cls);
    assign w_expire   = (r_wait == c_wait_last);
    assign w_dec_done = w_cls[c_cls_beq] | w_cls[c_cls_jal] | w_cls[c_cls_jr]
                      | w_cls[c_cls_nop] | w_illegal;

    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_s_fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_fetch:  w_state_next = c_s_decode;
            c_s_decode: w_state_next = w_dec_done ? c_s_fetch : c_s_exec;
            c_s_exec:   w_state_next = (w_cls[c_cls_lw] | w_cls[c_cls_sw]) ? c_s_mem : c_s_wb;
            c_s_mem: begin
                // An ack arriving on the expiry cycle still completes the access
                if (mem_ack) begin
                    w_state_next = w_cls[c_cls_lw] ? c_s_wb : c_s_fetch;
                end else if (w_expire) begin
                    w_state_next = c_s_fetch;
                end
            end
            c_s_wb:     w_state_next = c_s_fetch;
            default:    w_state_next = c_s_fetch;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock
    always_comb begin
        irwrite  = 1'b0;
        cpc      = 1'b0;
        isbeq    = 1'b0;
        cpcop    = c_pc_seq;
        regwrite = 1'b0;
        memwrite = 1'b0;
        mem_req  = 1'b0;
        alusrc   = 1'b0;
        aluctrl  = c_alu_add;
        extop    = c_ext_zero;
        regdst   = c_rd_rt;
        memtoreg = c_m2r_alu;
        if (reset) begin
            case (r_state)
                c_s_fetch: begin
                    irwrite = 1'b1;
                    cpc     = 1'b1;
                    cpcop   = c_pc_seq;
                end
                c_s_decode: begin
                    if (w_cls[c_cls_jal]) begin
                        cpc      = 1'b1;
                        cpcop    = c_pc_jal;
                        regwrite = 1'b1;
                        regdst   = c_rd_ra;
                        memtoreg = c_m2r_pc4;
                    end else if (w_cls[c_cls_jr]) begin
                        cpc   = 1'b1;
                        cpcop = c_pc_jr;
                    end else if (w_cls[c_cls_beq]) begin
                        cpc     = 1'b1;
                        isbeq   = 1'b1;
                        cpcop   = c_pc_br;
                        aluctrl = c_alu_sub;
                    end
                end
                c_s_exec: begin
                    {alusrc, aluctrl, extop} = w_alu;
                end
                c_s_mem: begin
                    {alusrc, aluctrl, extop} = w_alu;
                    mem_req  = 1'b1;
                    memwrite = mem_ack & w_cls[c_cls_sw];
                end
                c_s_wb: begin
                    {alusrc, aluctrl, extop} = w_alu;
                    regwrite = 1'b1;
                    if (w_cls[c_cls_addu] | w_cls[c_cls_subu]) begin
                        regdst = c_rd_rd;
                    end
                    if (w_cls[c_cls_lui]) begin
                        memtoreg = c_m2r_ext;
                    end else if (w_cls[c_cls_lw]) begin
                        memtoreg = c_m2r_dm;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= 4'd0;
        end else if (r_state != c_s_mem) begin
            if (w_state_next == c_s_mem) begin
                r_wait <= 4'd0;
            end
        end else if (r_wait != c_wait_max) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_illegal <= r_illegal | ((r_state == c_s_decode) & w_illegal);
            r_timeout <= r_timeout | ((r_state == c_s_mem) & ~mem_ack & w_expire);
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ret_cnt;

    assign cyc_cnt = r_cyc_cnt;
    assign ret_cnt = r_ret_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc_cnt <= 32'd0;
            r_ret_cnt <= 32'd0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if ((r_state != c_s_fetch) && (w_state_next == c_s_fetch)) begin
                r_ret_cnt <= r_ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Randomized self-checking bench for mc_ctrl against a per-instruction
//            cycle-trace model built from the instruction-class rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       irwrite;
        logic       cpc;
        logic       isbeq;
        logic [1:0] cpcop;
        logic       regwrite;
        logic       memwrite;
        logic       mem_req;
        logic       alusrc;
        logic [1:0] aluctrl;
        logic [1:0] extop;
        logic [1:0] regdst;
        logic [3:0] memtoreg;
        logic       illegal;
        logic       timeout;
    } outs_t;

    // Instruction kinds used by the model
    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_ILL = 10;
    localparam int MEM_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ack;
    logic        irwrite, cpc, isbeq, regwrite, memwrite, mem_req, alusrc, illegal, timeout;
    logic [1:0]  cpcop, aluctrl, extop, regdst;
    logic [3:0]  memtoreg;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_ins  = 0;
    bit          m_ill  = 1'b0;
    bit          m_to   = 1'b0;
    logic [31:0] m_cyc  = 32'd0;
    logic [31:0] m_ret  = 32'd0;
    outs_t       exp_q[$];
    int          ack_q[$];

    always #5 clk = ~clk;

    mc_ctrl #(.MAX_WAIT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .mem_ack  (mem_ack),
        .irwrite  (irwrite),
        .cpc      (cpc),
        .isbeq    (isbeq),
        .cpcop    (cpcop),
        .regwrite (regwrite),
        .memwrite (memwrite),
        .mem_req  (mem_req),
        .alusrc   (alusrc),
        .aluctrl  (aluctrl),
        .extop    (extop),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .state    (state),
        .illegal  (illegal),
        .timeout  (timeout)
`ifdef MC_CTRL_PERF_EN
        ,
        .cyc_cnt  (cyc_cnt),
        .ret_cnt  (ret_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    endtask

    function automatic outs_t observe();
        return {state, irwrite, cpc, isbeq, cpcop, regwrite, memwrite, mem_req,
                alusrc, aluctrl, extop, regdst, memtoreg, illegal, timeout};
    endfunction

    function automatic logic [31:0] make_instr(input int kind);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r = $urandom;
        case (kind)
            K_ADDU: return {6'b000000, r[25:11], 5'd0, 6'b100001};
            K_SUBU: return {6'b000000, r[25:11], 5'd0, 6'b100011};
            K_ORI:  return {6'b001101, r[25:0]};
            K_LUI:  return {6'b001111, r[25:0]};
            K_LW:   return {6'b100011, r[25:0]};
            K_SW:   return {6'b101011, r[25:0]};
            K_BEQ:  return {6'b000100, r[25:0]};
            K_JAL:  return {6'b000011, r[25:0]};
            K_JR:   return {6'b000000, r[25:21], 15'd0, 6'b001000};
            K_NOP:  return 32'd0;
            default: begin
                if (r[31]) begin
                    op = 6'($urandom);
                    while (op inside {6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03})
                        op = 6'($urandom);
                    return {op, r[25:0]};
                end else begin
                    fn = 6'($urandom);
                    while (fn inside {6'h21, 6'h23, 6'h08}) fn = 6'($urandom);
                    return {6'b000000, 5'($urandom_range(1, 31)), r[20:6], fn};
                end
            end
        endcase
    endfunction

    function automatic outs_t base(input logic [2:0] s);
        outs_t o;
        o         = '0;
        o.state   = s;
        o.illegal = m_ill;
        o.timeout = m_to;
        return o;
    endfunction

    function automatic outs_t with_alu(input outs_t oi, input int kind);
        outs_t o;
        o = oi;
        case (kind)
            K_SUBU: o.aluctrl = 2'b01;
            K_ORI:  begin o.alusrc = 1'b1; o.aluctrl = 2'b10; end
            K_LUI:  begin o.alusrc = 1'b1; o.aluctrl = 2'b11; o.extop = 2'b10; end
            K_LW, K_SW: begin o.alusrc = 1'b1; o.extop = 2'b01; end
            default: ;
        endcase
        return o;
    endfunction

    // Expected cycle trace of one instruction; ack code 2 means "don't care, drive random"
    task automatic build(input int kind, input int d);
        outs_t o;
        bit    acked;
        exp_q.delete();
        ack_q.delete();
        o = base(3'd0); o.irwrite = 1'b1; o.cpc = 1'b1;
        exp_q.push_back(o); ack_q.push_back(2);
        o = base(3'd1);
        case (kind)
            K_BEQ: begin o.cpc = 1'b1; o.isbeq = 1'b1; o.cpcop = 2'b01; o.aluctrl = 2'b01; end
            K_JAL: begin o.cpc = 1'b1; o.cpcop = 2'b10; o.regwrite = 1'b1; o.regdst = 2'b10; o.memtoreg = 4'd3; end
            K_JR:  begin o.cpc = 1'b1; o.cpcop = 2'b11; end
            default: ;
        endcase
        exp_q.push_back(o); ack_q.push_back(2);
        if (kind == K_ILL) m_ill = 1'b1;
        if (kind >= K_BEQ) return;
        exp_q.push_back(with_alu(base(3'd2), kind)); ack_q.push_back(2);
        if (kind == K_LW || kind == K_SW) begin
            acked = 1'b0;
            for (int k = 0; k < MEM_LIMIT && !acked; k++) begin
                o = with_alu(base(3'd3), kind);
                o.mem_req = 1'b1;
                acked = (k == d);
                o.memwrite = acked && (kind == K_SW);
                exp_q.push_back(o); ack_q.push_back(acked ? 1 : 0);
                if (!acked && k == MEM_LIMIT - 1) m_to = 1'b1;
            end
            if (kind == K_SW || !acked) return;
        end
        o = with_alu(base(3'd4), kind);
        o.regwrite = 1'b1;
        case (kind)
            K_ADDU, K_SUBU: o.regdst = 2'b01;
            K_LUI:          o.memtoreg = 4'd2;
            K_LW:           o.memtoreg = 4'd1;
            default: ;
        endcase
        exp_q.push_back(o); ack_q.push_back(2);
    endtask

    task automatic perf_check(input string tag);
`ifdef MC_CTRL_PERF_EN
        check_eq({tag, ".cyc"}, cyc_cnt, m_cyc);
        check_eq({tag, ".ret"}, ret_cnt, m_ret);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // stop_at >= 0 asserts reset asynchronously in that cycle of the instruction
    task automatic run_instr(input logic [31:0] iw, input int kind, input int d, input int stop_at);
        build(kind, d);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) instr = iw;
            mem_ack = (ack_q[i] == 2) ? 1'($urandom) : (ack_q[i] == 1);
            #1;
            check_eq($sformatf("ins%0d.k%0d.c%0d", n_ins, kind, i), {8'h0, observe()}, {8'h0, exp_q[i]});
            perf_check($sformatf("ins%0d.c%0d", n_ins, i));
            m_cyc++;
            if (i == stop_at) begin
                #2 reset = 1'b0;
                #1;
                check_eq("rst_mid", {8'h0, observe()}, 32'h0);
                m_ill = 1'b0; m_to = 1'b0; m_cyc = 32'd0; m_ret = 32'd0;
                perf_check("rst_mid");
                mem_ack = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
                n_ins++;
                return;
            end
        end
        m_ret++;
        n_ins++;
    endtask

    initial begin
        int kind;
        reset   = 1'b0;
        instr   = 32'd0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state", {8'h0, observe()}, 32'h0);
        perf_check("rst");
        instr   = 32'h8C000000;
        mem_ack = 1'b1;
        #1;
        check_eq("rst_inputs", {8'h0, observe()}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        mem_ack = 1'b0;

        run_instr(32'h00221821, K_ADDU, 0, -1);
        run_instr(make_instr(K_LW), K_LW, 2, -1);
        run_instr(make_instr(K_SW), K_SW, 0, -1);
        run_instr(make_instr(K_BEQ), K_BEQ, 0, -1);
        run_instr(32'hFC000000, K_ILL, 0, -1);
        run_instr(make_instr(K_SW), K_SW, 14, -1);
        run_instr(make_instr(K_SW), K_SW, 99, -1);
        run_instr(make_instr(K_JAL), K_JAL, 0, -1);
        run_instr(make_instr(K_SW), K_SW, 99, 6);
        run_instr(make_instr(K_LW), K_LW, 0, -1);
        run_instr(make_instr(K_LW), K_LW, 15, -1);
        run_instr(make_instr(K_NOP), K_NOP, 0, -1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 10);
            run_instr(make_instr(kind), kind, $urandom_range(0, 17), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
